// File: rtl/trig_pkg.sv
// Shared types and default widths for the wavetrace trigger path.
// Holds the trigger FSM state enum and the width constants that the
// capture controller also uses, so both sides agree on bus sizes.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } trig_state_e;

    localparam int TRIG_CNT_W  = 16;
    localparam int DEF_PROBE_W = 32;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_HOLD_W  = 16;
    localparam int DEF_MIN_GAP = 4;

endpackage

// File: rtl/trig_detect_if.sv
// Trigger detector control/status bundle.
// Latency: none (wires only).
// Backpressure: none; slave is the detector, master is the driver/software side.
interface trig_detect_if #(
    parameter int PROBE_W = trig_pkg::DEF_PROBE_W,
    parameter int CNT_W   = trig_pkg::DEF_CNT_W,
    parameter int HOLD_W  = trig_pkg::DEF_HOLD_W
);
    import trig_pkg::*;

    logic                  arm;
    logic                  disarm;
    logic                  rearm;
    logic [PROBE_W-1:0]    probe;
    logic [PROBE_W-1:0]    trig_value;
    logic [PROBE_W-1:0]    trig_mask;
    logic [PROBE_W-1:0]    edge_mask;
    logic [CNT_W-1:0]      match_count;
    logic [HOLD_W-1:0]     holdoff;
    logic                  trig_pulse;
    logic                  armed;
    logic                  triggered;
    logic [TRIG_CNT_W-1:0] trig_count;

    modport master (
        output arm, disarm, rearm, probe, trig_value, trig_mask, edge_mask,
               match_count, holdoff,
        input  trig_pulse, armed, triggered, trig_count
    );

    modport slave (
        input  arm, disarm, rearm, probe, trig_value, trig_mask, edge_mask,
               match_count, holdoff,
        output trig_pulse, armed, triggered, trig_count
    );

endinterface

// File: rtl/trig_match.sv
// Probe history and masked level/edge compare; cond_o is combinational on the registered samples.
// Latency: probe_i registered once; cond_o reflects the sample taken at the previous edge.
// Backpressure: none; free-running every sample clock.
// Ports: clk/rst_n, probe_i sample bus, cv_i/cm_i/ce_i captured value/mask/edge-mask, cond_o match.
module trig_match
    import trig_pkg::*;
#(
    parameter int PROBE_W = DEF_PROBE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic [PROBE_W-1:0] cv_i,
    input  logic [PROBE_W-1:0] cm_i,
    input  logic [PROBE_W-1:0] ce_i,
    output logic               cond_o
);

    logic [PROBE_W-1:0] probe_q;
    logic [PROBE_W-1:0] probe_qq;   // one sample older than probe_q
    logic [1:0]         hist_q;     // shifts in ones; bit 1 = both samples real

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_q  <= '0;
            probe_qq <= '0;
            hist_q   <= '0;
        end else begin
            probe_q  <= probe_i;
            probe_qq <= probe_q;
            hist_q   <= {hist_q[0], 1'b1};
        end
    end

    logic [PROBE_W-1:0] edge_bits;
    logic               lvl_ok;
    logic               edg_ok;

    always_comb begin
        edge_bits = ce_i & cm_i;
        lvl_ok    = (((probe_q ^ cv_i) & cm_i) == '0);
        // Edge bits must come from the opposite level, and that older
        // sample only counts once it was genuinely captured after reset.
        edg_ok    = (edge_bits == '0) ||
                    (hist_q[1] && (((probe_qq ^ cv_i) & edge_bits) == edge_bits));
        cond_o    = lvl_ok & edg_ok;
    end

endmodule

// File: rtl/trig_detect.sv
// Trigger detector: masked level/edge match, N consecutive matches, then one-cycle trig_pulse with holdoff.
// Latency: probe to trig_pulse is 2 edges at match_count<=1, +1 edge per extra required match.
// Backpressure: none; pulses are spaced by at least max(holdoff,MIN_GAP)+max(match_count,1) cycles.
// Ports: clk, rst_n (async active-low), bus (slave modport: arm/disarm/rearm, probe, config in; pulse/status out).
module trig_detect
    import trig_pkg::*;
#(
    parameter int PROBE_W = DEF_PROBE_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HOLD_W  = DEF_HOLD_W,
    parameter int MIN_GAP = DEF_MIN_GAP
) (
    input  logic          clk,
    input  logic          rst_n,
    trig_detect_if.slave  bus
);

    localparam logic [HOLD_W-1:0] MIN_GAP_V = HOLD_W'(MIN_GAP);

    trig_state_e           state_q, state_d;
    logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [PROBE_W-1:0]    cv_q, cv_d, cm_q, cm_d, ce_q, ce_d;
    logic [CNT_W-1:0]      cmc_q, cmc_d;
    logic [HOLD_W-1:0]     chold_q, chold_d;
    logic                  crearm_q, crearm_d;
    logic                  pulse_q, pulse_d;
    logic                  triggered_q, triggered_d;
    logic [TRIG_CNT_W-1:0] trig_count_q, trig_count_d;
    logic                  cond;

    trig_match #(.PROBE_W(PROBE_W)) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .probe_i (bus.probe),
        .cv_i    (cv_q),
        .cm_i    (cm_q),
        .ce_i    (ce_q),
        .cond_o  (cond)
    );

    logic [HOLD_W-1:0] hold_load;
    logic [CNT_W-1:0]  need_cnt;
    logic [CNT_W:0]    run_inc;
    logic              run_hit;

    always_comb begin
        hold_load = (chold_q < MIN_GAP_V) ? MIN_GAP_V : chold_q;
        need_cnt  = (cmc_q == '0) ? CNT_W'(1) : cmc_q;
        run_inc   = {1'b0, run_cnt_q} + (CNT_W+1)'(1);
        run_hit   = (run_inc >= {1'b0, need_cnt});
    end

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cv_d         = cv_q;
        cm_d         = cm_q;
        ce_d         = ce_q;
        cmc_d        = cmc_q;
        chold_d      = chold_q;
        crearm_d     = crearm_q;
        pulse_d      = 1'b0;
        triggered_d  = triggered_q;
        trig_count_d = trig_count_q;

        if (bus.disarm) begin
            // Abort wins over arm and over a match landing this cycle;
            // status is kept so software can still read it.
            state_d   = ST_IDLE;
            run_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        cv_d         = bus.trig_value;
                        cm_d         = bus.trig_mask;
                        ce_d         = bus.edge_mask;
                        cmc_d        = bus.match_count;
                        chold_d      = bus.holdoff;
                        crearm_d     = bus.rearm;
                        triggered_d  = 1'b0;
                        trig_count_d = '0;
                        run_cnt_d    = '0;
                        state_d      = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!cond) begin
                        run_cnt_d = '0;
                    end else if (run_hit) begin
                        pulse_d      = 1'b1;
                        triggered_d  = 1'b1;
                        trig_count_d = (&trig_count_q) ? trig_count_q
                                                       : trig_count_q + TRIG_CNT_W'(1);
                        run_cnt_d    = '0;
                        if (crearm_q) begin
                            state_d    = ST_HOLDOFF;
                            hold_cnt_d = hold_load;
                        end else begin
                            state_d    = ST_DONE;
                        end
                    end else begin
                        run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    // Holds for exactly hold_load cycles; <=1 also guards a zero load.
                    if (hold_cnt_q <= HOLD_W'(1)) begin
                        state_d   = ST_ARMED;
                        run_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            cv_q         <= '0;
            cm_q         <= '0;
            ce_q         <= '0;
            cmc_q        <= '0;
            chold_q      <= '0;
            crearm_q     <= 1'b0;
            pulse_q      <= 1'b0;
            triggered_q  <= 1'b0;
            trig_count_q <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            cv_q         <= cv_d;
            cm_q         <= cm_d;
            ce_q         <= ce_d;
            cmc_q        <= cmc_d;
            chold_q      <= chold_d;
            crearm_q     <= crearm_d;
            pulse_q      <= pulse_d;
            triggered_q  <= triggered_d;
            trig_count_q <= trig_count_d;
        end
    end

    assign bus.trig_pulse = pulse_q;
    assign bus.armed      = (state_q != ST_IDLE);
    assign bus.triggered  = triggered_q;
    assign bus.trig_count = trig_count_q;

endmodule

// File: tb/tb_trig_detect.sv
// Bench for trig_detect: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model (sample history + "resume edge" bookkeeping).
module tb_trig_detect;
    import trig_pkg::*;

    localparam int PW = 32;
    localparam int CW = 8;
    localparam int HW = 16;
    localparam int MG = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trig_detect_if #(.PROBE_W(PW), .CNT_W(CW), .HOLD_W(HW)) bus ();

    trig_detect #(.PROBE_W(PW), .CNT_W(CW), .HOLD_W(HW), .MIN_GAP(MG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint        n_edge;              // edges since reset release
    logic [PW-1:0] h_new, h_old;        // last two probe samples
    int            h_cnt;               // how many real samples exist (capped at 2)
    bit            m_active, m_done, m_rearm, m_pulse, m_trig;
    int            m_run, m_need, m_hold;
    longint        m_resume;            // first edge at which matches count again
    logic [PW-1:0] m_cv, m_cm, m_ce;
    int            m_count;

    function automatic bit model_cond(input logic [PW-1:0] q, input logic [PW-1:0] d,
                                      input logic [PW-1:0] cv, input logic [PW-1:0] cm,
                                      input logic [PW-1:0] ce, input bit hv);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < PW; i++) begin
            if (cm[i]) begin
                if (q[i] != cv[i]) ok = 1'b0;
                if (ce[i] && (!hv || d[i] == cv[i])) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0; h_new = '0; h_old = '0; h_cnt = 0;
            m_active = 0; m_done = 0; m_rearm = 0; m_pulse = 0; m_trig = 0;
            m_run = 0; m_need = 1; m_hold = MG; m_resume = 0;
            m_cv = '0; m_cm = '0; m_ce = '0; m_count = 0;
        end else begin
            bit c;
            n_edge++;
            m_pulse = 0;
            c = model_cond(h_new, h_old, m_cv, m_cm, m_ce, h_cnt >= 2);
            if (bus.disarm) begin
                m_active = 0;
            end else if (!m_active) begin
                if (bus.arm) begin
                    m_active = 1; m_done = 0; m_trig = 0; m_count = 0; m_run = 0;
                    m_cv = bus.trig_value; m_cm = bus.trig_mask; m_ce = bus.edge_mask;
                    m_need = (bus.match_count == 0) ? 1 : int'(bus.match_count);
                    m_hold = (int'(bus.holdoff) < MG) ? MG : int'(bus.holdoff);
                    m_rearm = bus.rearm;
                    m_resume = n_edge + 1;
                end
            end else if (!m_done && n_edge >= m_resume) begin
                if (c) begin
                    m_run++;
                    if (m_run >= m_need) begin
                        m_pulse = 1; m_trig = 1; m_run = 0;
                        if (m_count < 65535) m_count++;
                        if (m_rearm) m_resume = n_edge + m_hold + 1;
                        else         m_done = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            h_old = h_new;
            h_new = bus.probe;
            if (h_cnt < 2) h_cnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        check("pulse",     bus.trig_pulse, m_pulse);
        check("armed",     bus.armed,      m_active);
        check("triggered", bus.triggered,  m_trig);
        check("count",     bus.trig_count, m_count);
        check("back2back", prev_pulse & bus.trig_pulse, 1'b0);
        prev_pulse = bus.trig_pulse;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [PW-1:0] cv, input logic [PW-1:0] cm, input logic [PW-1:0] ce,
                       input int cmc, input int hold, input bit rr);
        bus.trig_value  = cv;
        bus.trig_mask   = cm;
        bus.edge_mask   = ce;
        bus.match_count = CW'(cmc);
        bus.holdoff     = HW'(hold);
        bus.rearm       = rr;
    endtask

    task automatic do_disarm();
        bus.disarm = 1'b1; tick(); bus.disarm = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        bus.arm = 0; bus.disarm = 0; bus.probe = '0;
        cfg('0, '0, '0, 1, 0, 0);

        // reset state
        repeat (3) tick();
        check("rst_pulse", bus.trig_pulse, 0);
        check("rst_armed", bus.armed, 0);
        check("rst_trig",  bus.triggered, 0);
        check("rst_count", bus.trig_count, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // level match, one-shot
        r = $urandom();
        cfg(32'h5A, 32'hFF, '0, 1, 0, 0);
        bus.probe = {r[31:8], 8'h00};
        bus.arm = 1; tick(); bus.arm = 0;
        bus.probe = {r[31:8], 8'h5A}; tick();
        check("lvl_pre", bus.trig_pulse, 0);
        bus.probe = {r[31:8], 8'h00}; tick();
        check("lvl_pulse", bus.trig_pulse, 1);
        check("lvl_count", bus.trig_count, 1);
        tick();
        check("lvl_post", bus.trig_pulse, 0);
        bus.probe = {r[31:8], 8'h5A}; repeat (4) tick();
        check("lvl_done_count", bus.trig_count, 1);
        check("lvl_done_armed", bus.armed, 1);
        do_disarm(); tick();
        check("lvl_dis_armed", bus.armed, 0);
        check("lvl_dis_trig",  bus.triggered, 1);

        // rising edge with re-arm: level held from before arm never fires
        r = $urandom();
        cfg(32'h1, 32'h1, 32'h1, 1, 0, 1);
        bus.probe = {r[31:1], 1'b1}; repeat (2) tick();
        bus.arm = 1; tick(); bus.arm = 0;
        repeat (4) tick();
        check("edge_noheld", bus.triggered, 0);
        bus.probe = {r[31:1], 1'b0}; tick();
        bus.probe = {r[31:1], 1'b1}; tick();
        check("edge_pre", bus.trig_pulse, 0);
        tick();
        check("edge_pulse", bus.trig_pulse, 1);
        repeat (10) tick();
        check("edge_norepeat", bus.trig_count, 1);
        do_disarm();

        // consecutive-match count
        cfg(32'h3, 32'hF, '0, 3, 0, 0);
        bus.probe = '0;
        bus.arm = 1; tick(); bus.arm = 0;
        bus.probe = 32'h3; repeat (2) tick();
        bus.probe = 32'h0; tick();
        bus.probe = 32'h3; repeat (2) tick();
        check("cnt_short_run", bus.triggered, 0);
        tick();
        bus.probe = 32'h0;
        check("cnt_pre", bus.trig_pulse, 0);
        tick();
        check("cnt_pulse", bus.trig_pulse, 1);
        do_disarm();

        // holdoff below MIN_GAP with re-arm: a pulse every 5 cycles
        cfg('0, '0, '0, 1, 1, 1);
        bus.arm = 1; tick(); bus.arm = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("hold_period", bus.trig_pulse, (i % 5) == 1);
            if (i == 11) check("hold_count3", bus.trig_count, 3);
        end
        do_disarm();

        // disarm lands on the final match
        cfg(32'h11, 32'hFF, '0, 1, 0, 1);
        bus.probe = '0;
        bus.arm = 1; tick(); bus.arm = 0;
        bus.probe = 32'h11; tick();
        bus.probe = 32'h0; tick();
        check("dis_first", bus.trig_count, 1);
        repeat (8) tick();
        bus.probe = 32'h11; tick();
        bus.probe = 32'h0; bus.disarm = 1; tick(); bus.disarm = 0;
        check("dis_pulse", bus.trig_pulse, 0);
        check("dis_armed", bus.armed, 0);
        check("dis_count", bus.trig_count, 1);
        check("dis_trig",  bus.triggered, 1);

        // async reset while the pulse is high (state HOLDOFF)
        cfg('0, '0, '0, 1, 10, 1);
        bus.arm = 1; tick(); bus.arm = 0;
        tick();
        check("ar_pulse_hi", bus.trig_pulse, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_pulse", bus.trig_pulse, 0);
        check("ar_armed", bus.armed, 0);
        check("ar_trig",  bus.triggered, 0);
        check("ar_count", bus.trig_count, 0);
        repeat (2) tick();
        // edge pattern armed straight out of reset: needs real history first
        r = $urandom();
        cfg(32'h1, 32'h1, 32'h1, 1, 0, 0);
        bus.probe = {r[31:1], 1'b1};
        rst_n = 1'b1; bus.arm = 1; tick(); bus.arm = 0;
        repeat (6) tick();
        check("hv_nofire", bus.triggered, 0);
        check("hv_armed",  bus.armed, 1);
        bus.probe = {r[31:1], 1'b0}; tick();
        bus.probe = {r[31:1], 1'b1}; tick();
        tick();
        check("hv_fire", bus.trig_pulse, 1);
        do_disarm();

        // randomized run against the model
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ($urandom_range(0, 49) == 0)
                cfg($urandom(), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            bus.arm    = ($urandom_range(0, 7) == 0);
            bus.disarm = ($urandom_range(0, 59) == 0);
            r = $urandom();
            if ($urandom_range(0, 9) < 6) bus.probe = {r[31:4], bus.trig_value[3:0]};
            else                          bus.probe = r;
            if (cyc == 1200) begin
                #3 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        bus.arm = 0; bus.disarm = 0;
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
